// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: shares one register-file write port between pipeline writeback (A) and multi-cycle unit (B); optional bypass via RF_WB_BYPASS_EN
module regfile_write_arbiter #(
  parameter int DATA_WIDTH   = 32,
  parameter int REG_BITS     = 5,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clock,
  input  logic                  ctrl_reset,
  input  logic                  a_valid,
  output logic                  a_ready,
  input  logic [REG_BITS-1:0]   a_reg,
  input  logic [DATA_WIDTH-1:0] a_data,
  input  logic                  b_valid,
  output logic                  b_ready,
  input  logic [REG_BITS-1:0]   b_reg,
  input  logic [DATA_WIDTH-1:0] b_data,
  output logic                  rf_we,
  output logic [REG_BITS-1:0]   rf_reg,
  output logic [DATA_WIDTH-1:0] rf_data,
  input  logic [REG_BITS-1:0]   byp_reg,
  output logic                  byp_hit,
  output logic [DATA_WIDTH-1:0] byp_data
);
  logic [3:0] wait_cnt;
  logic       force_b;
  assign force_b = wait_cnt == 4'(STARVE_LIMIT);
  // A has priority unless B has been blocked long enough; nothing is granted during reset
  always_comb begin
    b_ready = ~ctrl_reset & b_valid & (~a_valid | force_b);
    a_ready = ~ctrl_reset & a_valid & ~(b_valid & force_b);
  end
  // one-stage write register; writes to register 0 are accepted but never enabled
  always_ff @(posedge clock) begin
    if (ctrl_reset) begin
      rf_we    <= 1'b0;
      rf_reg   <= '0;
      rf_data  <= '0;
      wait_cnt <= '0;
    end else begin
      rf_we <= (a_ready && a_reg != '0) || (b_ready && b_reg != '0);
      if (a_ready || b_ready) begin
        rf_reg  <= b_ready ? b_reg : a_reg;
        rf_data <= b_ready ? b_data : a_data;
      end
      wait_cnt <= (!b_valid || b_ready) ? 4'd0 : force_b ? wait_cnt : wait_cnt + 4'd1;
    end
  end
`ifdef RF_WB_BYPASS_EN
  assign byp_hit  = rf_we && rf_reg == byp_reg && byp_reg != '0;
  assign byp_data = byp_hit ? rf_data : '0;
`else
  logic unused_byp;
  assign unused_byp = ^byp_reg;
  assign byp_hit    = 1'b0;
  assign byp_data   = '0;
`endif
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb_regfile_write_arbiter: vector table, hand sequences and randomized model comparison
module tb_regfile_write_arbiter;
  localparam int DW = 32, RB = 5, SL = 4, NV = 12;
  logic clock = 0, ctrl_reset = 1, a_valid = 0, b_valid = 0;
  logic [RB-1:0] a_reg = 0, b_reg = 0, byp_reg = 0;
  logic [DW-1:0] a_data = 0, b_data = 0;
  logic a_ready, b_ready, rf_we, byp_hit;
  logic [RB-1:0] rf_reg;
  logic [DW-1:0] rf_data, byp_data;
  int checks = 0, errors = 0;
  int starve = 0;
  logic m_we = 0;
  logic [RB-1:0] m_reg = 0;
  logic [DW-1:0] m_data = 0;
  logic la, lb;
  typedef struct {
    logic av; logic [RB-1:0] ar; logic [DW-1:0] ad;
    logic bv; logic [RB-1:0] br; logic [DW-1:0] bd;
    logic ea, eb, ewe; logic [RB-1:0] ereg; logic [DW-1:0] edata;
  } vec_t;
  vec_t tv [NV];

  always #5 clock = ~clock;

  regfile_write_arbiter #(.DATA_WIDTH(DW), .REG_BITS(RB), .STARVE_LIMIT(SL)) dut (
    .clock(clock), .ctrl_reset(ctrl_reset),
    .a_valid(a_valid), .a_ready(a_ready), .a_reg(a_reg), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_reg(b_reg), .b_data(b_data),
    .rf_we(rf_we), .rf_reg(rf_reg), .rf_data(rf_data),
    .byp_reg(byp_reg), .byp_hit(byp_hit), .byp_data(byp_data)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // one clock with the reference model: B wins when it has waited SL blocked cycles or A is idle
  task automatic cycle(output logic ga, output logic gb);
    logic eh;
    #1;
    gb = !ctrl_reset && b_valid && (!a_valid || starve >= SL);
    ga = !ctrl_reset && a_valid && !gb;
    chk("a_ready", a_ready, ga);
    chk("b_ready", b_ready, gb);
    @(posedge clock);
    if (ctrl_reset) begin
      m_we = 0; m_reg = 0; m_data = 0; starve = 0;
    end else begin
      m_we = (ga && a_reg != 0) || (gb && b_reg != 0);
      if (ga) begin m_reg = a_reg; m_data = a_data; end
      if (gb) begin m_reg = b_reg; m_data = b_data; end
      starve = (b_valid && !gb) ? (starve < SL ? starve + 1 : SL) : 0;
    end
    #1;
    chk("rf_we", rf_we, m_we);
    chk("rf_reg", rf_reg, m_reg);
    chk("rf_data", rf_data, m_data);
`ifdef RF_WB_BYPASS_EN
    eh = m_we && m_reg == byp_reg && byp_reg != 0;
`else
    eh = 0;
`endif
    chk("byp_hit", byp_hit, eh);
    chk("byp_data", byp_data, eh ? m_data : 0);
  endtask

  task automatic drive(input logic av, input logic [RB-1:0] ar, input logic [DW-1:0] ad,
                       input logic bv, input logic [RB-1:0] br, input logic [DW-1:0] bd);
    a_valid = av; a_reg = ar; a_data = ad; b_valid = bv; b_reg = br; b_data = bd;
  endtask

  initial begin
    tv[0]  = '{1, 5, 32'hDEADBEEF, 0, 0, 0,          1, 0, 1, 5, 32'hDEADBEEF};
    tv[1]  = '{0, 0, 0,            0, 0, 0,          0, 0, 0, 5, 32'hDEADBEEF};
    tv[2]  = '{1, 3, 32'h11,       1, 7, 32'h22,     1, 0, 1, 3, 32'h11};
    tv[3]  = '{0, 0, 0,            1, 7, 32'h22,     0, 1, 1, 7, 32'h22};
    tv[4]  = '{1, 1, 32'h100,      1, 9, 32'hABCD,   1, 0, 1, 1, 32'h100};
    tv[5]  = '{1, 2, 32'h101,      1, 9, 32'hABCD,   1, 0, 1, 2, 32'h101};
    tv[6]  = '{1, 3, 32'h102,      1, 9, 32'hABCD,   1, 0, 1, 3, 32'h102};
    tv[7]  = '{1, 4, 32'h103,      1, 9, 32'hABCD,   1, 0, 1, 4, 32'h103};
    tv[8]  = '{1, 5, 32'h104,      1, 9, 32'hABCD,   0, 1, 1, 9, 32'hABCD};
    tv[9]  = '{1, 5, 32'h104,      0, 0, 0,          1, 0, 1, 5, 32'h104};
    tv[10] = '{0, 0, 0,            1, 0, 32'hFFFF,   0, 1, 0, 0, 32'hFFFF};
    tv[11] = '{0, 0, 0,            0, 0, 0,          0, 0, 0, 0, 32'hFFFF};
    @(posedge clock); #1;
    chk("reset_a_ready", a_ready, 0);
    @(posedge clock); #1;
    chk("reset_rf_we", rf_we, 0);
    chk("reset_rf_reg", rf_reg, 0);
    chk("reset_rf_data", rf_data, 0);
    chk("reset_byp_hit", byp_hit, 0);
    ctrl_reset = 0;
    for (int i = 0; i < NV; i++) begin
      drive(tv[i].av, tv[i].ar, tv[i].ad, tv[i].bv, tv[i].br, tv[i].bd);
      #1;
      chk($sformatf("vec%0d_a_ready", i), a_ready, tv[i].ea);
      chk($sformatf("vec%0d_b_ready", i), b_ready, tv[i].eb);
      @(posedge clock); #1;
      chk($sformatf("vec%0d_rf_we", i), rf_we, tv[i].ewe);
      chk($sformatf("vec%0d_rf_reg", i), rf_reg, tv[i].ereg);
      chk($sformatf("vec%0d_rf_data", i), rf_data, tv[i].edata);
    end
    ctrl_reset = 1;
    cycle(la, lb);
    ctrl_reset = 0;
    for (int k = 0; k < 3; k++) begin
      drive(1, 6, 32'h60 + k, 1, 10, 32'hB0);
      cycle(la, lb);
    end
    chk("pre_reset_rf_we", rf_we, 1);
    ctrl_reset = 1;
    drive(1, 6, 32'h70, 1, 10, 32'hB0);
    cycle(la, lb);
    chk("midreset_rf_we", rf_we, 0);
    ctrl_reset = 0;
    for (int k = 0; k < 5; k++) begin
      drive(1, 6, 32'h80 + k, 1, 10, 32'hB0);
      #1;
      chk($sformatf("post_reset_b_ready%0d", k), b_ready, k == 4);
      chk($sformatf("post_reset_a_ready%0d", k), a_ready, k != 4);
      cycle(la, lb);
    end
    chk("forced_b_rf_reg", rf_reg, 10);
    drive(1, 12, 32'h1234, 0, 0, 0);
    cycle(la, lb);
    drive(0, 0, 0, 0, 0, 0);
    byp_reg = 12;
    #1;
`ifdef RF_WB_BYPASS_EN
    chk("byp12_hit", byp_hit, 1);
    chk("byp12_data", byp_data, 32'h1234);
`else
    chk("byp12_hit", byp_hit, 0);
    chk("byp12_data", byp_data, 0);
`endif
    byp_reg = 0;
    #1;
    chk("byp0_hit", byp_hit, 0);
    la = 1; lb = 1;
    for (int n = 0; n < 3000; n++) begin
      ctrl_reset = $urandom_range(99) == 0;
      if (!a_valid || la) begin
        a_valid = $urandom_range(3) != 0;
        a_reg = RB'($urandom_range(7));
        a_data = $urandom;
      end
      if (!b_valid || lb) begin
        b_valid = $urandom_range(1) != 0;
        b_reg = RB'($urandom_range(7));
        b_data = $urandom;
      end
      byp_reg = $urandom_range(1) ? m_reg : RB'($urandom_range(7));
      cycle(la, lb);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
